// File: rtl/fpu_share_arbiter.sv
// Round-robin sharing of one external FPU port between NREQ requesters.
// Results are steered back to their requester through a fixed-depth tag delay line.
module fpu_share_arbiter #(
  parameter int NREQ = 2,
  parameter int LAT  = 4,
  parameter int DLAT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*5-1:0]  op,
  input  logic [NREQ*32-1:0] a,
  input  logic [NREQ*32-1:0] b,
  output logic [NREQ-1:0]    gnt,
  output logic [31:0]        fpu1in,
  output logic [31:0]        fpu2in,
  output logic [4:0]         fpuen,
  input  logic [31:0]        fpuout,
  output logic [NREQ-1:0]    rvalid,
  output logic [31:0]        rdata,
  output logic               busy
);

  localparam int IDXW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW      = $clog2(DLAT + 1);
  localparam int PIPE_SLOT = DLAT - LAT;

  logic [IDXW-1:0] last_grant_q, last_grant_d;
  logic            busy_q, busy_d;
  logic [CNTW-1:0] busy_cnt_q, busy_cnt_d;
  logic [31:0]     fpu1in_q, fpu1in_d, fpu2in_q, fpu2in_d;
  logic [4:0]      fpuen_q, fpuen_d;
  logic            iss_valid_q, iss_valid_d;
  logic            iss_iter_q, iss_iter_d;
  logic [IDXW-1:0] iss_id_q, iss_id_d;
  logic [DLAT-1:0] tag_vld_q, tag_vld_d;
  logic [IDXW-1:0] tag_id_q [DLAT];
  logic [IDXW-1:0] tag_id_d [DLAT];
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [NREQ-1:0] gnt_s;
  logic [IDXW-1:0] win_s, cand_s;
  logic            win_vld_s;
  logic [4:0]      sel_op_s;
  logic [31:0]     sel_a_s, sel_b_s;

  // Round-robin pick starting one past the last winner; nothing is granted while busy or in reset.
  always_comb begin
    gnt_s     = '0;
    win_s     = '0;
    cand_s    = '0;
    win_vld_s = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = IDXW'((int'(last_grant_q) + k) % NREQ);
      if (!win_vld_s && req[cand_s] && !busy_q && reset) begin
        win_vld_s = 1'b1;
        win_s     = cand_s;
      end else begin
        win_vld_s = win_vld_s;
      end
    end
    if (win_vld_s) begin
      gnt_s[win_s] = 1'b1;
    end else begin
      gnt_s = '0;
    end
    sel_op_s = op[int'(win_s)*5 +: 5];
    sel_a_s  = a[int'(win_s)*32 +: 32];
    sel_b_s  = b[int'(win_s)*32 +: 32];
  end

  // Issue register, busy window and issue record for the tag line.
  always_comb begin
    last_grant_d = last_grant_q;
    fpu1in_d     = fpu1in_q;
    fpu2in_d     = fpu2in_q;
    fpuen_d      = 5'b00000;
    iss_valid_d  = 1'b0;
    iss_iter_d   = 1'b0;
    iss_id_d     = iss_id_q;
    busy_d       = busy_q;
    busy_cnt_d   = busy_cnt_q;
    if (busy_q) begin
      if (busy_cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        busy_cnt_d = busy_cnt_q - CNTW'(1);
      end
    end else begin
      busy_cnt_d = busy_cnt_q;
    end
    if (win_vld_s) begin
      last_grant_d = win_s;
      fpu1in_d     = sel_a_s;
      fpu2in_d     = sel_b_s;
      fpuen_d      = sel_op_s;
      iss_valid_d  = |sel_op_s;
      iss_iter_d   = sel_op_s[4];
      iss_id_d     = win_s;
      // Busy covers T+1..T+DLAT-1, so the counter starts at DLAT-2.
      if (sel_op_s[4] && (DLAT > 1)) begin
        busy_d     = 1'b1;
        busy_cnt_d = CNTW'(DLAT - 2);
      end else begin
        busy_d     = busy_q;
      end
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Tag delay line: a tag reaches the last stage in the cycle its fpuout is valid.
  always_comb begin
    tag_vld_d[0] = 1'b0;
    tag_id_d[0]  = tag_id_q[0];
    for (int j = 1; j < DLAT; j++) begin
      tag_vld_d[j] = tag_vld_q[j-1];
      tag_id_d[j]  = tag_id_q[j-1];
    end
    if (iss_valid_q) begin
      if (iss_iter_q) begin
        tag_vld_d[0] = 1'b1;
        tag_id_d[0]  = iss_id_q;
      end else begin
        tag_vld_d[PIPE_SLOT] = 1'b1;
        tag_id_d[PIPE_SLOT]  = iss_id_q;
      end
    end else begin
      tag_vld_d[0] = 1'b0;
    end
  end

  // Result capture for the emerging tag.
  always_comb begin
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (tag_vld_q[DLAT-1]) begin
      rvalid_d[tag_id_q[DLAT-1]] = 1'b1;
      rdata_d                    = fpuout;
    end else begin
      rvalid_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= IDXW'(NREQ - 1);
      busy_q       <= 1'b0;
      busy_cnt_q   <= '0;
      fpu1in_q     <= 32'h0000_0000;
      fpu2in_q     <= 32'h0000_0000;
      fpuen_q      <= 5'b00000;
      iss_valid_q  <= 1'b0;
      iss_iter_q   <= 1'b0;
      iss_id_q     <= '0;
      tag_vld_q    <= '0;
      for (int j = 0; j < DLAT; j++) begin
        tag_id_q[j] <= '0;
      end
      rvalid_q     <= '0;
      rdata_q      <= 32'h0000_0000;
    end else begin
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      busy_cnt_q   <= busy_cnt_d;
      fpu1in_q     <= fpu1in_d;
      fpu2in_q     <= fpu2in_d;
      fpuen_q      <= fpuen_d;
      iss_valid_q  <= iss_valid_d;
      iss_iter_q   <= iss_iter_d;
      iss_id_q     <= iss_id_d;
      tag_vld_q    <= tag_vld_d;
      for (int j = 0; j < DLAT; j++) begin
        tag_id_q[j] <= tag_id_d[j];
      end
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

  assign gnt    = gnt_s;
  assign fpu1in = fpu1in_q;
  assign fpu2in = fpu2in_q;
  assign fpuen  = fpuen_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign busy   = busy_q;

endmodule

// File: doc/fpu_share_arbiter.md
# fpu_share_arbiter

Shares the single external FPU port of the system (fpu1in/fpu2in/fpuen/fpuout) between NREQ requesters, typically multiple cores. Arbitration is round-robin. Requests are issued into the pipelined FPU one per cycle. Iterative operations (divide/sqrt class) occupy the FPU exclusively until they complete. A tag pipeline routes each result back to its requester. The block sits between the cores' FPU ports and the top-level FPU pins.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..8)
- LAT, 4, pipelined-op latency: fpuen cycle to fpuout valid (>=1)
- DLAT, 16, iterative-op latency: fpuen cycle to fpuout valid (DLAT >= LAT)

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  NREQ  request per requester; held until granted; may be withdrawn before grant
- op  in  NREQ*5  5-bit one-hot op per requester (slice i = bits 5i+4:5i); bit 4 = iterative class
- a  in  NREQ*32  operand 1 per requester
- b  in  NREQ*32  operand 2 per requester
- gnt  out  NREQ  combinational one-hot grant; request accepted this cycle
- fpu1in  out  32  registered operand 1 to FPU
- fpu2in  out  32  registered operand 2 to FPU
- fpuen  out  5  registered op strobe to FPU, nonzero for exactly one cycle per issue
- fpuout  in  32  FPU result, valid LAT or DLAT cycles after the fpuen cycle
- rvalid  out  NREQ  registered one-cycle result strobe, one-hot
- rdata  out  32  registered result, shared by all requesters
- busy  out  1  iterative op in progress; no grants

## Operation
- Eligibility: a request is eligible when req[i]=1 and busy=0.
- Arbitration: round-robin. The search starts at last_grant+1 mod NREQ. The first eligible index wins, and last_grant is updated to that index. At most one gnt bit is set per cycle.
- Issue: in the grant cycle T, the chosen a/b/op are registered. In cycle T+1, fpu1in=a, fpu2in=b, fpuen=op. In all other cycles fpuen=0 and fpu1in/fpu2in hold their last values.
- Zero op: a granted request with op=0 consumes the grant. fpuen stays 0 and no result is ever returned.
- Multi-hot op: treated as iterative if bit 4 is set, otherwise as pipelined. The value is passed through unchanged.
- Pipelined op (bit4=0): back-to-back issue every cycle is allowed.
- Iterative op (bit4=1): granted in T, busy=1 for cycles T+1..T+DLAT-1, and the next grant is possible at T+DLAT. This ordering guarantees at most one result per cycle.
- Tag tracking: each issue records its requester index and return time. A tag delay line of depth DLAT is sufficient: pipelined ops enter at offset DLAT-LAT, iterative ops at offset 0.
- Return: when a tag emerges in cycle R (fpuout valid), rdata<=fpuout and rvalid[id]<=1 at the end of R. rvalid is high for cycle R+1 only.
- Results return strictly in order of return time. A requester may have multiple pipelined ops outstanding.
- A requester withdrawing req before gnt is legal. A req still high in the cycle after gnt is a new request.

## Timing
- Reset (reset=0, asynchronous): fpuen=0, fpu1in=0, fpu2in=0, rvalid=0, rdata=0, busy=0, last_grant=NREQ-1 (requester 0 wins first), all tags invalid. gnt=0 while reset=0.
- Reset mid-operation discards all in-flight tags. No rvalid is produced for them, even if fpuout later changes.
- Latency from gnt to rvalid is LAT+2 cycles for pipelined ops and DLAT+2 for iterative ops.
- A grant and a result return in the same cycle are independent and both proceed.
- busy is registered and is deasserted in the same cycle the next grant becomes possible (T+DLAT).

## Test plan
(NREQ=2, LAT=4, DLAT=16)
- Reset release, req=01, op0=00001, a0=0x3F800000, b0=0x40000000 held one cycle -> gnt=01 in cycle 0; fpuen=00001 with fpu1in/fpu2in=those operands in cycle 1; model drives fpuout=0x40400000 in cycle 5; rvalid=01, rdata=0x40400000 in cycle 6 only.
- req=11 held 4 cycles, both ops pipelined -> gnt sequence 01,10,01,10; fpuen nonzero cycles 1-4; rvalid sequence 01,10,01,10 in cycles 6-9, each matching its own fpuout value.
- Requester 0 issues iterative op (00000+bit4=10000) in cycle 0 while req1 held -> busy=1 cycles 1-15; gnt=10 first in cycle 16; rvalid=01 in cycle 18; requester 1 rvalid=10 in cycle 22.
- Pipelined op from requester 1 in cycle 0, iterative op from requester 0 in cycle 1 -> rvalid=10 in cycle 6, rvalid=01 in cycle 19, never two rvalid bits in one cycle.
- Pull reset low in cycle 3 after a pipelined issue in cycle 0 -> all outputs 0 immediately; after release, no rvalid in cycles 6-10 despite fpuout toggling; next request granted to requester 0.
- Granted request with op=0 -> fpuen stays 0, no rvalid within 30 cycles, and the next request from the other requester is granted the following cycle.
